ab_input_debounce: RTL and testbench
====================================

# ab_input_debounce

Two-channel input conditioning stage that sits directly upstream of the `xor_and_not` gate example and drives its `a` and `b` inputs from raw, asynchronous, bouncy board signals such as push-buttons or DIP switches. Each channel is optionally synchronized, then debounced by a per-channel stability counter and state machine. The block also emits a one-cycle change strobe so downstream logic or a bench can react to accepted input changes.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive differing samples required before an output is updated. Legal range: 2 ≤ STABLE_CYCLES < 2^CNT_W.
- `CNT_W`, default 8: width of each channel's stability counter.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `a_i`  in  1  raw channel A; asynchronous and may bounce.
- `b_i`  in  1  raw channel B; asynchronous and may bounce.
- `a_o`  out  1  debounced A, registered; feeds `xor_and_not.a`.
- `b_o`  out  1  debounced B, registered; feeds `xor_and_not.b`.
- `chg_o`  out  1  one-cycle pulse on the edge where `a_o` or `b_o` changes.

## Operation
- Per-channel sample `s`:
  - With `AB_INPUT_DEBOUNCE_SYNC_EN` defined, `s` is the output of a 2-flop synchronizer.
  - Without it, `s` is the raw input captured in one register.
- Per-channel FSM has two states, STABLE and CHECK, plus counter `cnt`.
  - **STABLE:** if `s == out`, hold with `cnt = 0`. If `s != out`, set `cnt = 1` and go to CHECK.
  - **CHECK:** if `s == out`, this is a glitch: set `cnt = 0` and go to STABLE; `out` is unchanged.
  - **CHECK:** if `s != out` and `cnt == STABLE_CYCLES-1`, set `out = s`, `cnt = 0`, go to STABLE, and raise this channel's change flag. Otherwise increment `cnt`.
- `out` therefore updates on the STABLE_CYCLES-th consecutive edge on which `s != out`.
  - Any agreeing sample restarts the count from 0.
  - `cnt` never exceeds STABLE_CYCLES-1 and never wraps.
- `chg_o` is the registered OR of both channels' change flags.
  - It is high for exactly one cycle, aligned with the output update.
  - If both channels update on the same edge, a single pulse is produced.
- The two channels are fully independent apart from the shared `chg_o`.

## Timing
- Reset, applied on any edge with `rst_n == 0`:
  - `a_o`, `b_o` and `chg_o` = 0.
  - Synchronizer flops = 0, `cnt` = 0, state = STABLE.
- Reset in the middle of a count discards that count entirely. After release, counting restarts from fresh samples.
- Outputs in the first cycle after reset release are still 0.
- Latency, counted from the first edge that captures a new stable raw level (edge 0):
  - With sync enabled: `out` and `chg_o` update at edge STABLE_CYCLES+1. The default gives edge 5.
  - With sync disabled: they update at edge STABLE_CYCLES-1. The default gives edge 3.
- `chg_o` falls on the following edge unless the other channel updates on that edge.
- A pulse on the raw input shorter than STABLE_CYCLES sample periods never reaches the output.

## Configuration
- Macro `AB_INPUT_DEBOUNCE_SYNC_EN`:
  - Defined: a 2-flop metastability synchronizer is inserted per channel. This is the required setting for board builds with real pins.
  - Undefined: the raw input is registered once. Latency drops by 2 cycles and the filter behaviour is otherwise identical. This setting is intended for simulation-only benches driven from the same clock.
- No ports, parameters or reset values differ between the two builds.

## Test plan
All scenarios use STABLE_CYCLES=4 with the macro defined; clock period 2 units.

1. **Reset:** hold `rst_n = 0` for 3 edges with `a_i = b_i = 1`. Required: `a_o = b_o = chg_o = 0` throughout and in the first cycle after release.
2. **Single rise:** set `a_i` 0→1 and hold it. Required: `a_o = 1` and `chg_o = 1` at edge 5 after the first capturing edge, then `chg_o = 0` at edge 6; `b_o` stays 0.
3. **Glitch rejection:** drive `a_i = 1` for 3 cycles, then 0. Required: `a_o` stays 0 and `chg_o` never asserts.
4. **Bounce:** drive `a_i` as 1, 0, 1, 0, then hold 1. Required: `a_o` rises exactly 5 edges after the capturing edge of the final rise, with one `chg_o` pulse.
5. **Simultaneous change:** raise `a_i` and `b_i` in the same cycle. Required: `a_o` and `b_o` rise on the same edge with a single one-cycle `chg_o`. Also drive all four a/b combinations and check that the downstream `z` follows the debounced values.
6. **Reset mid-count:** drop `rst_n` for one edge 3 edges into an `a_i` rise. Required: outputs stay 0. After release, `a_o = 1` at edge 5 counted from the first post-reset capturing edge.

Source files
------------

// File: rtl/ab_input_debounce_if.sv
// ab_input_debounce_if
//   Bundles the raw board inputs and the debounced outputs of
//   ab_input_debounce.
//   a_i, b_i   raw, asynchronous, possibly bouncing channel inputs
//   a_o, b_o   debounced channel levels (feed xor_and_not.a / .b)
//   chg_o      one-cycle strobe when either debounced level changes
//   slave  : the debounce block (consumes a_i/b_i, drives outputs)
//   master : the environment (drives a_i/b_i, observes outputs)
interface ab_input_debounce_if;
  logic a_i;
  logic b_i;
  logic a_o;
  logic b_o;
  logic chg_o;

  modport slave  (input  a_i, b_i, output a_o, b_o, chg_o);
  modport master (output a_i, b_i, input  a_o, b_o, chg_o);
endinterface

// File: rtl/ab_input_debounce.sv
// ab_input_debounce
//   Two-channel input conditioner: each raw input is (optionally)
//   synchronized, then filtered by a stability counter / 2-state FSM.
//   A debounced output only moves after STABLE_CYCLES consecutive
//   samples that disagree with it; any agreeing sample restarts the count.
//
//   Optional feature macro: AB_INPUT_DEBOUNCE_SYNC_EN
//     defined   : 2-flop synchronizer per channel (board builds)
//     undefined : the FSM registers the raw input directly
//                 (same-clock simulation benches, 2 cycles less latency)
//
//   Parameters
//     STABLE_CYCLES  disagreeing samples needed to accept a change (>=2)
//     CNT_W          stability counter width (STABLE_CYCLES < 2**CNT_W)
//   Ports
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    ab_input_debounce_if.slave (a_i, b_i in; a_o, b_o, chg_o out)

// Per-channel filter. out_o is registered; upd_o is the combinational
// "out_o updates on this edge" flag, registered once at the top into chg_o
// so the strobe lines up with the output change.
module ab_input_debounce_lane #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic out_o,
  output logic upd_o
);
  typedef enum logic {ST_STABLE, ST_CHECK} st_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  st_t              st_q;
  logic [CNT_W-1:0] cnt_q;
  logic             out_q;
  logic             s;

`ifdef AB_INPUT_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw_i};
  end

  assign s = sync_q[1];
`else
  // The FSM state register is the single capture stage of the raw pin.
  assign s = raw_i;
`endif

  assign upd_o = (st_q == ST_CHECK) && (s != out_q) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= ST_STABLE;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      case (st_q)
        ST_STABLE: begin
          if (s != out_q) begin
            cnt_q <= CNT_W'(1);
            st_q  <= ST_CHECK;
          end else begin
            cnt_q <= '0;
          end
        end
        ST_CHECK: begin
          if (s == out_q) begin
            // glitch: drop the partial count, keep the old level
            cnt_q <= '0;
            st_q  <= ST_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            out_q <= s;
            cnt_q <= '0;
            st_q  <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q <= '0;
          st_q  <= ST_STABLE;
        end
      endcase
    end
  end

  assign out_o = out_q;
endmodule

module ab_input_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ab_input_debounce_if.slave    bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] dout;
  logic [NUM_LANES-1:0] upd;
  logic                 chg_q;

  // lane 0 = A, lane 1 = B
  assign raw = {bus.b_i, bus.a_i};

  ab_input_debounce_lane #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_lane [NUM_LANES-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (raw),
    .out_o (dout),
    .upd_o (upd)
  );

  // Simultaneous updates on both lanes collapse into one pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) chg_q <= 1'b0;
    else        chg_q <= |upd;
  end

  assign bus.a_o   = dout[0];
  assign bus.b_o   = dout[1];
  assign bus.chg_o = chg_q;
endmodule

// File: tb/tb_ab_input_debounce.sv
// tb_ab_input_debounce
//   Scoreboard bench: each stimulus step pushes the expected
//   {a_o, b_o, chg_o} for every upcoming edge; the values are popped and
//   compared on the falling edge after that rising edge.
module tb_ab_input_debounce;
  localparam int SC = 4;
`ifdef AB_INPUT_DEBOUNCE_SYNC_EN
  localparam int LAT = SC + 1;
`else
  localparam int LAT = SC - 1;
`endif

  typedef struct {
    int   cyc;
    logic a;
    logic b;
    logic chg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   ecnt;
  int   n_cmp;
  int   n_err;
  logic cur_a, cur_b;
  exp_t sb[$];

  ab_input_debounce_if ifc ();

  ab_input_debounce #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial ecnt = 0;
  always @(posedge clk) ecnt = ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic exp_one(input int c, input logic a, input logic b, input logic chg);
    exp_t e;
    e.cyc = c; e.a = a; e.b = b; e.chg = chg;
    sb.push_back(e);
  endtask

  task automatic exp_rng(input int c0, input int c1, input logic a, input logic b, input logic chg);
    for (int c = c0; c <= c1; c++) exp_one(c, a, b, chg);
  endtask

  // Pop everything due by the current edge and compare.
  task automatic sb_check();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= ecnt) begin
      e = sb.pop_front();
      if (e.cyc < ecnt) chk($sformatf("late@%0d", e.cyc), ecnt, e.cyc);
      chk($sformatf("a_o@%0d", e.cyc),   ifc.a_o,   e.a);
      chk($sformatf("b_o@%0d", e.cyc),   ifc.b_o,   e.b);
      chk($sformatf("chg_o@%0d", e.cyc), ifc.chg_o, e.chg);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
  endtask

  // Drive a new stable level pair and expect it after LAT edges.
  task automatic apply(input logic na, input logic nb);
    int e0;
    e0 = ecnt + 1;
    ifc.a_i = na;
    ifc.b_i = nb;
    exp_rng(e0, e0 + LAT - 1, cur_a, cur_b, 1'b0);
    exp_one(e0 + LAT, na, nb, (na != cur_a) || (nb != cur_b));
    exp_rng(e0 + LAT + 1, e0 + LAT + 2, na, nb, 1'b0);
    cur_a = na;
    cur_b = nb;
    repeat (LAT + 3) tick();
  endtask

  // Raise a_i for w samples (w < SC): must never reach a_o.
  task automatic pulse(input int w);
    int e0;
    e0 = ecnt + 1;
    ifc.a_i = 1'b1;
    exp_rng(e0, e0 + w + LAT + 2, cur_a, cur_b, 1'b0);
    repeat (w) tick();
    ifc.a_i = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  initial begin
    int e0;
    n_cmp = 0;
    n_err = 0;
    cur_a = 1'b0;
    cur_b = 1'b0;
    rst_n = 1'b0;
    ifc.a_i = 1'b1;
    ifc.b_i = 1'b1;

    // reset held for 3 edges with inputs high, plus first cycle after release
    exp_rng(1, 4, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    // drop inputs: the brief high seen after release is a glitch
    ifc.a_i = 1'b0;
    ifc.b_i = 1'b0;
    exp_rng(ecnt + 1, ecnt + LAT + 4, 1'b0, 1'b0, 1'b0);
    repeat (LAT + 4) tick();

    // single rise / fall on A, B stays 0
    apply(1'b1, 1'b0);
    apply(1'b0, 1'b0);

    // glitch rejection
    pulse(3);
    pulse(1);

    // bounce 1,0,1,0 then hold 1
    e0 = ecnt + 1;
    exp_rng(e0, e0 + 3, 1'b0, 1'b0, 1'b0);
    ifc.a_i = 1'b1; tick();
    ifc.a_i = 1'b0; tick();
    ifc.a_i = 1'b1; tick();
    ifc.a_i = 1'b0; tick();
    apply(1'b1, 1'b0);
    apply(1'b0, 1'b0);

    // simultaneous change, then walk all a/b combinations
    apply(1'b1, 1'b1);
    apply(1'b1, 1'b0);
    apply(1'b0, 1'b1);
    apply(1'b0, 1'b0);

    // reset pulse 3 edges into an A rise
    e0 = ecnt + 1;
    ifc.a_i = 1'b1;
    exp_rng(e0, e0 + 4 + LAT - 1, 1'b0, 1'b0, 1'b0);
    exp_one(e0 + 4 + LAT, 1'b1, 1'b0, 1'b1);
    exp_one(e0 + 5 + LAT, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (LAT + 2) tick();
    cur_a = 1'b1;
    cur_b = 1'b0;
    apply(1'b0, 1'b0);

    repeat (4) tick();
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
